// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: widths, round count, schedule FSM states and the
// one-bit left rotate used by both the message schedule and compression.
package sha1_pkg;

  localparam int SHA1_ROUNDS = 80;
  localparam int SHA1_WORD_W = 32;
  localparam int SHA1_BLK_W  = 512;
  localparam int SHA1_WIN    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sha1_state_e;

  function automatic logic [SHA1_WORD_W-1:0] rotl1(input logic [SHA1_WORD_W-1:0] x);
    return {x[SHA1_WORD_W-2:0], x[SHA1_WORD_W-1]};
  endfunction

endpackage

// File: rtl/sha1_w_window.sv
// 16-word sliding window of the SHA-1 schedule. win_q[0] is always the word
// for the current round; a shift drops it and appends the next recurrence word.
module sha1_w_window
  import sha1_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [SHA1_BLK_W-1:0]  blk_data_i,
  output logic [SHA1_WORD_W-1:0] w0_o
);

  logic [SHA1_WORD_W-1:0] win_q [SHA1_WIN];
  logic [SHA1_WORD_W-1:0] win_d [SHA1_WIN];
  logic [SHA1_WORD_W-1:0] tap;

  // W[t+16] = ROTL1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]) relative to the window head
  assign tap = rotl1(win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0]);

  // Next window: load the big-endian block, shift in the recurrence word, or hold
  always_comb begin
    for (int i = 0; i < SHA1_WIN; i++) begin
      win_d[i] = win_q[i];
    end
    if (load_i) begin
      for (int i = 0; i < SHA1_WIN; i++) begin
        win_d[i] = blk_data_i[SHA1_BLK_W-1-i*SHA1_WORD_W -: SHA1_WORD_W];
      end
    end else if (shift_i) begin
      for (int i = 0; i < SHA1_WIN-1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[SHA1_WIN-1] = tap;
    end
  end

  // Window registers, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SHA1_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SHA1_WIN; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign w0_o = win_q[0];

endmodule

// File: rtl/sha1_msg_sched.sv
// SHA-1 message schedule: accepts one padded 512-bit block and presents
// W[0..79] one word per step, then pulses done for one cycle.
//
// Handshakes: blk_valid_i/blk_ready_o transfer a block on any rising edge
// where both are high. w_valid_o/step_i: the word on w_out_o/w_idx_o is
// consumed on any rising edge where both are high; with step_i low the word
// holds. step_i while w_valid_o is low is ignored.
module sha1_msg_sched
  import sha1_pkg::*;
#(
  parameter int ROUNDS = SHA1_ROUNDS,
  parameter int IDX_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   blk_valid_i,
  input  logic [SHA1_BLK_W-1:0]  blk_data_i,
  output logic                   blk_ready_o,
  input  logic                   step_i,
  output logic                   w_valid_o,
  output logic [SHA1_WORD_W-1:0] w_out_o,
  output logic [IDX_W-1:0]       w_idx_o,
  output logic                   done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  sha1_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   load, shift, last;
  logic [SHA1_WORD_W-1:0] w0;

  assign last = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a block starts a run, stepping the last word ends it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (blk_valid_i)   state_d = RUN;
      RUN:     if (step_i && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from the current state
  always_comb begin
    blk_ready_o = (state_q == IDLE);
    w_valid_o   = (state_q == RUN);
    load        = (state_q == IDLE) && blk_valid_i;
    shift       = (state_q == RUN) && step_i && !last;
    done_d      = (state_q == RUN) && step_i && last;
    idx_d       = idx_q;
    if (load || done_d) begin
      idx_d = '0;
    end else if (shift) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Round counter and done pulse
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  sha1_w_window u_window (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (load),
    .shift_i    (shift),
    .blk_data_i (blk_data_i),
    .w0_o       (w0)
  );

  // Stale window contents are hidden outside a run
  assign w_out_o = w_valid_o ? w0 : '0;
  assign w_idx_o = idx_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Bench for sha1_msg_sched: a SHA-1 schedule model expands each block with
// plain array arithmetic into exp_q; each scenario walks the DUT against it.
module tb_sha1_msg_sched;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         blk_valid_i;
  logic [511:0] blk_data_i;
  logic         blk_ready_o;
  logic         step_i;
  logic         w_valid_o;
  logic [31:0]  w_out_o;
  logic [7:0]   w_idx_o;
  logic         done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  exp_q[$];
  logic [511:0] abc_blk;
  logic [511:0] ones_blk;

  sha1_msg_sched #(.ROUNDS(80), .IDX_W(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .blk_valid_i (blk_valid_i),
    .blk_data_i  (blk_data_i),
    .blk_ready_o (blk_ready_o),
    .step_i      (step_i),
    .w_valid_o   (w_valid_o),
    .w_out_o     (w_out_o),
    .w_idx_o     (w_idx_o),
    .done_o      (done_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: W[t] = block word t for t<16, else ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16])
  task automatic model_fill(input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] x;
    exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      if (i < 16) begin
        w[i] = blk[511-32*i -: 32];
      end else begin
        x    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
        w[i] = {x[30:0], x[31]};
      end
      exp_q.push_back(w[i]);
    end
  endtask

  // Driver: present a block for one cycle (called on a negedge, state must be idle)
  task automatic load_block(input logic [511:0] blk);
    @(negedge clk_i);
    blk_valid_i = 1'b1;
    blk_data_i  = blk;
    step_i      = 1'b0;
  endtask

  // Walk one block. mode 0: step always; 1: step pattern 1,0,0,1; 2: random.
  // intrude holds blk_valid high with an all-ones block during the run.
  // abort_at >= 0 returns after checking that word, before stepping it.
  // chain=1 returns on the done cycle so the caller can load back-to-back.
  task automatic stream(input logic [511:0] blk, input int mode, input bit intrude,
                        input int abort_at, input bit chain, input bit known);
    int t;
    int k;
    int cyc;
    logic st;
    logic [31:0] kexp;
    model_fill(blk);
    t = 0; k = 0; cyc = 0;
    while (t < 80 && cyc < 2000) begin
      @(negedge clk_i);
      blk_valid_i = intrude;
      if (intrude) blk_data_i = ones_blk;
      n_checks++;
      if (w_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL run_w_valid t=%0d got %b expected 1", t, w_valid_o);
      end
      n_checks++;
      if (w_idx_o !== 8'(t)) begin
        n_fail++; $display("FAIL run_w_idx got %0d expected %0d", w_idx_o, t);
      end
      n_checks++;
      if (w_out_o !== exp_q[0]) begin
        n_fail++; $display("FAIL run_w_out t=%0d got %h expected %h", t, w_out_o, exp_q[0]);
      end
      n_checks++;
      if (blk_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL run_blk_ready t=%0d got %b expected 0", t, blk_ready_o);
      end
      n_checks++;
      if (done_o !== 1'b0) begin
        n_fail++; $display("FAIL run_done t=%0d got %b expected 0", t, done_o);
      end
      if (known && (t == 16 || t == 17 || t == 18)) begin
        kexp = (t == 16) ? 32'hC2C4C700 : (t == 17) ? 32'h00000000 : 32'h00000030;
        n_checks++;
        if (w_out_o !== kexp) begin
          n_fail++; $display("FAIL abc_known t=%0d got %h expected %h", t, w_out_o, kexp);
        end
      end
      if (abort_at == t) begin
        step_i = 1'b0;
        return;
      end
      case (mode)
        0:       st = 1'b1;
        1:       st = ((k % 4) == 0) || ((k % 4) == 3);
        default: st = 1'($urandom_range(0, 1));
      endcase
      step_i = st;
      k++; cyc++;
      if (st) begin
        t++;
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (t < 80) begin
      n_fail++; $display("FAIL run_timeout reached t=%0d expected 80", t);
    end
    @(negedge clk_i);
    step_i      = 1'b0;
    blk_valid_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse got %b expected 1", done_o);
    end
    n_checks++;
    if (w_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL done_w_valid got %b expected 0", w_valid_o);
    end
    n_checks++;
    if (blk_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL done_blk_ready got %b expected 1", blk_ready_o);
    end
    if (!chain) begin
      @(negedge clk_i);
      n_checks++;
      if (done_o !== 1'b0 || w_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL after_done got done=%b w_valid=%b expected 0/0", done_o, w_valid_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i     = 1'b0;
    blk_valid_i = 1'b1;
    blk_data_i  = abc_blk;
    step_i      = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      n_checks++;
      if (w_valid_o !== 1'b0 || w_out_o !== 32'h0 || w_idx_o !== 8'h0 ||
          done_o !== 1'b0 || blk_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_values got valid=%b out=%h idx=%0d done=%b ready=%b expected 0/0/0/0/1",
                 w_valid_o, w_out_o, w_idx_o, done_o, blk_ready_o);
      end
    end
    rst_n_i     = 1'b1;
    blk_valid_i = 1'b0;
    step_i      = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (w_valid_o !== 1'b0 || blk_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_no_load got valid=%b ready=%b expected 0/1", w_valid_o, blk_ready_o);
    end
  endtask

  task automatic test_idle_step();
    step_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      n_checks++;
      if (w_valid_o !== 1'b0 || w_idx_o !== 8'h0 || done_o !== 1'b0) begin
        n_fail++; $display("FAIL idle_step got valid=%b idx=%0d done=%b expected 0/0/0",
                           w_valid_o, w_idx_o, done_o);
      end
    end
    step_i = 1'b0;
  endtask

  task automatic test_abc();
    load_block(abc_blk);
    stream(abc_blk, 0, 1'b0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_step_toggle();
    load_block(abc_blk);
    stream(abc_blk, 1, 1'b0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_blk_ignored();
    load_block(abc_blk);
    stream(abc_blk, 0, 1'b1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk2;
    for (int i = 0; i < 16; i++) blk2[511-32*i -: 32] = $urandom;
    load_block(abc_blk);
    stream(abc_blk, 0, 1'b0, -1, 1'b1, 1'b1);
    blk_valid_i = 1'b1;
    blk_data_i  = blk2;
    stream(blk2, 0, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    load_block(abc_blk);
    stream(abc_blk, 0, 1'b0, 40, 1'b0, 1'b0);
    rst_n_i = 1'b0;
    step_i  = 1'b1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step_i  = 1'b0;
    n_checks++;
    if (w_valid_o !== 1'b0 || blk_ready_o !== 1'b1 || w_idx_o !== 8'h0 ||
        done_o !== 1'b0 || w_out_o !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state got valid=%b ready=%b idx=%0d done=%b out=%h expected 0/1/0/0/0",
               w_valid_o, blk_ready_o, w_idx_o, done_o, w_out_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0 || w_valid_o !== 1'b0 || blk_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL abort_no_done got done=%b valid=%b ready=%b expected 0/0/1",
                         done_o, w_valid_o, blk_ready_o);
    end
    load_block(abc_blk);
    stream(abc_blk, 0, 1'b0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [511:0] blk;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom;
      load_block(blk);
      stream(blk, 2, 1'b0, -1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    abc_blk  = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    ones_blk = {16{32'hFFFFFFFF}};
    test_reset();
    test_idle_step();
    test_abc();
    test_step_toggle();
    test_blk_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha1_msg_sched.md
Name: sha1_msg_sched

Overview:
SHA-1 message-schedule stage. It sits directly downstream of the round controller (sha1_con) and feeds the compression datapath. It accepts one padded 512-bit block, then emits W[0..79], one 32-bit word per advance strobe. The controller drives `step` once per round (its ready_t/t cadence); this block reports the round index it is serving.

Parameters:
ROUNDS, 80, number of schedule words per block; only 80 is supported.
IDX_W, 8, width of the round-index output; matches the controller's t width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; synchronous, active-low
blk_valid  input  1  padded block available on blk_data
blk_data  input  512  block, big-endian: word0 = [511:480], word15 = [31:0]
blk_ready  output  1  block can be accepted this cycle
step  input  1  consume the current W word and advance one round
w_valid  output  1  w_out/w_idx hold a valid schedule word
w_out  output  32  current W[t]
w_idx  output  IDX_W  current t, 0..79
done  output  1  one-cycle pulse after W[79] is consumed

Behaviour:
- Reset: synchronous, active-low; sampled on the clk rising edge. Values while rst_n=0 (outputs take them at the next edge):
  - state=IDLE; blk_ready=1 (combinational from IDLE);
  - w_valid=0, w_out=0, w_idx=0, done=0;
  - all 16 window registers = 0.
- Reset mid-RUN aborts the block. No done pulse is issued. The block is idle and ready on the first cycle after rst_n returns high.
- State IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid=1: load window w[i] = word i for i=0..15; w_idx=0; go to RUN.
  - First word is visible the next cycle: w_valid=1, w_out=blk_data[511:480]. Load-to-first-word latency is 1 cycle.
- State RUN:
  - blk_ready=0, w_valid=1, w_out=w[0], w_idx=current t.
  - blk_valid is ignored; the block is not latched and no error is flagged.
  - step=0: hold all registers; the word stays stable indefinitely.
  - step=1, w_idx<79: shift the window down (w[i] <= w[i+1], i=0..14). Set w[15] <= ROTL1(w[13]^w[8]^w[2]^w[0]) and increment w_idx. The next word is visible the following cycle.
  - This recurrence holds for every step. For t<16 the window supplies the loaded words directly, so the first 16 outputs equal the block words.
  - step=1, w_idx=79: go to IDLE. done=1 for exactly the next cycle, with w_valid=0 in that cycle.
  - blk_ready is high in that same done cycle. A blk_valid in the done cycle loads a new block, giving back-to-back blocks with one bubble cycle.
- step while IDLE: ignored.
- Arithmetic:
  - ROTL1(x) = {x[30:0], x[31]}.
  - XOR is 32-bit; there is no carry arithmetic.
  - w_idx never exceeds 79. Wrap back to 0 happens only through a new load.
- Throughput: 80 words in 80 cycles with step held high.

Decomposition:
- Shared sha1_pkg holds:
  - SHA1_ROUNDS=80, SHA1_WORD_W=32, SHA1_BLK_W=512;
  - state enum {IDLE, RUN};
  - rotl1 function, reused by the compression stage.
- One natural sub-module: sha1_w_window. It holds the 16x32 shift register with load/shift enables and the recurrence tap; FSM and counter stay in the parent.

Test Plan:
1. "abc" padded block (word0=0x61626380, words1-14=0, word15=0x00000018), step held 1. W0..W15 must equal the block words, then:
   - W16=0xC2C4C700, W17=0x00000000, W18=0x00000030;
   - w_idx must run 0..79 consecutively;
   - done pulses once in the cycle after w_idx=79 is stepped.
2. Same block with step toggled 1,0,0,1 pattern. w_out/w_idx must hold stable while step=0. The final word sequence must be identical to scenario 1.
3. blk_valid held 1 throughout RUN with a different block (all 0xFFFFFFFF). blk_ready must stay 0, and the outputs must match scenario 1 exactly.
4. Back-to-back: second block presented in the done cycle. It is accepted there, and the second block's w_valid/W0 appears on the next cycle.
5. rst_n low for 1 cycle at w_idx=40. On the next cycle: w_valid=0, blk_ready=1, w_idx=0, no done. A fresh "abc" block then reproduces scenario 1.
6. Reset values: hold rst_n=0 with blk_valid=1 and step=1. Outputs must stay at reset values and no load may occur.
